// File: rtl/sat_adder_rr_arbiter_if.sv
// Request/response bundle between requesters and the shared saturating adder.
// The master side drives requests; the slave side (the adder) returns results.
interface sat_adder_rr_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_signed;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_po;
  logic                     rsp_no;
  logic [NUM_REQ-1:0]       ovf_clr;
  logic [NUM_REQ-1:0]       ovf_sticky;

  modport master (
    output req_valid, req_a, req_b, req_signed, rsp_ready, ovf_clr,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_po, rsp_no, ovf_sticky
  );

  modport slave (
    input  req_valid, req_a, req_b, req_signed, rsp_ready, ovf_clr,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_po, rsp_no, ovf_sticky
  );
endinterface

// File: rtl/sat_adder_rr_arbiter.sv
// Round-robin shared saturating adder with one registered response stage
// and a sticky overflow flag per requester.
module sat_adder_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  sat_adder_rr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         win_idx;
  logic [IDW:0]           cand;
  logic                   win_found, can_accept, accept;
  logic [2*NUM_REQ-1:0]   valid_dbl;
  logic [NUM_REQ-1:0]     valid_rot, grant;
  logic [WIDTH-1:0]       a_sel, b_sel, res_w;
  logic                   sgn_sel, po_w, no_w;
  logic [WIDTH:0]         sum_w;

  logic                   rsp_valid_q;
  logic [IDW-1:0]         rsp_id_q;
  logic [WIDTH-1:0]       rsp_result_q;
  logic                   rsp_po_q, rsp_no_q;
  logic [NUM_REQ-1:0]     sticky_q, sticky_d;

  // Rotate valids so bit 0 is the pointer; the lowest set bit wins.
  always_comb begin
    valid_dbl = {bus.req_valid, bus.req_valid};
    valid_rot = valid_dbl[ptr_q +: NUM_REQ];
    win_found = |bus.req_valid;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        cand = {1'b0, ptr_q} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
        win_idx = cand[IDW-1:0];
      end
    end
  end

  assign can_accept = !rsp_valid_q || bus.rsp_ready;
  assign accept     = win_found && can_accept;
  assign grant      = NUM_REQ'(1) << win_idx;
  assign bus.req_ready = accept ? grant : '0;
  assign ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sgn_sel = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDW'(k)) begin
        a_sel   = bus.req_a[k*WIDTH +: WIDTH];
        b_sel   = bus.req_b[k*WIDTH +: WIDTH];
        sgn_sel = bus.req_signed[k];
      end
    end
  end

  always_comb begin
    sum_w = {1'b0, a_sel} + {1'b0, b_sel};
    po_w  = 1'b0;
    no_w  = 1'b0;
    res_w = sum_w[WIDTH-1:0];
    if (sgn_sel) begin
      po_w = !a_sel[WIDTH-1] && !b_sel[WIDTH-1] &&  sum_w[WIDTH-1];
      no_w =  a_sel[WIDTH-1] &&  b_sel[WIDTH-1] && !sum_w[WIDTH-1];
      if (po_w) res_w = {1'b0, {(WIDTH-1){1'b1}}};
      if (no_w) res_w = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      po_w = sum_w[WIDTH];
      if (po_w) res_w = '1;
    end
  end

  // A set from this cycle's overflow overrides a same-cycle clear.
  assign sticky_d = (sticky_q & ~bus.ovf_clr) | ((accept && (po_w || no_w)) ? grant : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_po_q     <= 1'b0;
      rsp_no_q     <= 1'b0;
      sticky_q     <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (accept) begin
        ptr_q        <= ptr_d;
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= win_idx;
        rsp_result_q <= res_w;
        rsp_po_q     <= po_w;
        rsp_no_q     <= no_w;
      end else if (bus.rsp_ready) begin
        rsp_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_po     = rsp_po_q;
  assign bus.rsp_no     = rsp_no_q;
  assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_sat_adder_rr_arbiter.sv
// Randomized and directed checks of sat_adder_rr_arbiter (WIDTH=8, NUM_REQ=4)
// against an integer-arithmetic reference model.
module tb_sat_adder_rr_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  sat_adder_rr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  sat_adder_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  int         m_ptr;
  bit         m_valid;
  int         m_id, m_res;
  bit         m_po, m_no;
  logic [3:0] m_sticky;
  logic [3:0] obs_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void sat_ref(input int a, input int b, input bit sg,
                                  output int res, output bit po, output bit no);
    int sa, sb, s;
    po = 0; no = 0;
    if (sg) begin
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      s  = sa + sb;
      if (s > 127)       begin po = 1; res = 127; end
      else if (s < -128) begin no = 1; res = 128; end
      else               res = s & 255;
    end else begin
      s = a + b;
      if (s > 255) begin po = 1; res = 255; end
      else         res = s;
    end
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_res = 0; m_po = 0; m_no = 0; m_sticky = '0;
  endtask

  task automatic check_outputs();
    chk("rsp_valid",  bus.rsp_valid,  m_valid);
    chk("rsp_id",     bus.rsp_id,     m_id);
    chk("rsp_result", bus.rsp_result, m_res);
    chk("rsp_po",     bus.rsp_po,     m_po);
    chk("rsp_no",     bus.rsp_no,     m_no);
    chk("ovf_sticky", bus.ovf_sticky, m_sticky);
  endtask

  // One clock cycle: drive after negedge, check grant before the edge,
  // advance the model at the edge, check registered outputs at negedge.
  task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] sg, input logic rr, input logic [3:0] clr);
    int win; bit found, acc; logic [3:0] exp_ready;
    int res; bit po, no;
    bus.req_valid = v; bus.req_a = a; bus.req_b = b; bus.req_signed = sg;
    bus.rsp_ready = rr; bus.ovf_clr = clr;
    #1;
    found = 0; win = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (!found && v[j]) begin found = 1; win = j; end
    end
    acc = found && (!m_valid || rr);
    exp_ready = acc ? 4'(1 << win) : 4'b0000;
    obs_ready = bus.req_ready;
    chk("req_ready", bus.req_ready, exp_ready);
    @(posedge clk);
    m_sticky = m_sticky & ~clr;
    if (acc) begin
      sat_ref(int'((a >> (win*8)) & 32'hFF), int'((b >> (win*8)) & 32'hFF), sg[win], res, po, no);
      m_valid = 1; m_id = win; m_res = res; m_po = po; m_no = no;
      if (po || no) m_sticky[win] = 1'b1;
      m_ptr = (win + 1) % N;
    end else if (rr) begin
      m_valid = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid",  bus.rsp_valid,  1'b0);
    chk("rst_sticky", bus.ovf_sticky, 4'b0000);
    chk("rst_result", bus.rsp_result, 8'h00);
    model_reset();
    bus.req_valid = '0; bus.rsp_ready = 1'b0; bus.ovf_clr = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] held;
    int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_signed = '0;
    bus.rsp_ready = 1'b0; bus.ovf_clr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 0, 0, 0, 1, 0);
    do_reset();

    // signed saturation
    step(4'b0001, 32'h00000070, 32'h00000020, 4'b1111, 1, 0);
    chk("sig_po_res", bus.rsp_result, 8'h7F);
    chk("sig_po_flag", bus.rsp_po, 1'b1);
    chk("sig_sticky0", bus.ovf_sticky[0], 1'b1);
    step(4'b0010, 32'h00008000, 32'h0000F000, 4'b1111, 1, 0);
    chk("sig_no_res", bus.rsp_result, 8'h80);
    chk("sig_no_flag", bus.rsp_no, 1'b1);
    step(4'b0100, 32'h00050000, 32'h00FE0000, 4'b1111, 1, 0);
    chk("sig_plain", bus.rsp_result, 8'h03);
    // unsigned saturation
    step(4'b1000, 32'hF0000000, 32'h20000000, 4'b0000, 1, 0);
    chk("uns_po_res", bus.rsp_result, 8'hFF);
    step(4'b0001, 32'h00000010, 32'h00000020, 4'b0000, 1, 0);
    chk("uns_plain", bus.rsp_result, 8'h30);
    step(4'b0010, 32'h00008000, 32'h00008000, 4'b0000, 1, 0);
    chk("uns_no_zero", bus.rsp_no, 1'b0);

    // round-robin fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, $urandom, $urandom, 4'($urandom), 1, 0);
      chk("rr_id", bus.rsp_id, exp_ids[i]);
      chk("rr_valid", bus.rsp_valid, 1'b1);
    end

    // backpressure: hold for three cycles, then grant requester 2
    held = bus.rsp_result;
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, $urandom, $urandom, 4'($urandom), 0, 0);
      chk("bp_hold", bus.rsp_result, held);
    end
    step(4'b1111, $urandom, $urandom, 4'($urandom), 1, 0);
    chk("bp_grant", obs_ready, 4'b0100);
    chk("bp_next_id", bus.rsp_id, 2'd2);

    // sticky clear/set collision
    step(4'b0000, 0, 0, 0, 1, 4'b1111);
    chk("stk_clr_all", bus.ovf_sticky, 4'b0000);
    step(4'b0001, 32'h00000070, 32'h00000020, 4'b0001, 1, 4'b0001);
    chk("stk_collide", bus.ovf_sticky[0], 1'b1);
    step(4'b0000, 0, 0, 0, 1, 4'b0001);
    chk("stk_clr0", bus.ovf_sticky[0], 1'b0);

    // reset with a pending response
    step(4'b0001, 32'h00000001, 32'h00000001, 0, 0, 0);
    chk("pend_valid", bus.rsp_valid, 1'b1);
    do_reset();
    step(4'b1111, $urandom, $urandom, 4'($urandom), 1, 0);
    chk("post_rst_id", bus.rsp_id, 2'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), $urandom, $urandom, 4'($urandom),
           ($urandom_range(0, 9) < 7), 4'($urandom & $urandom & $urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sat_adder_rr_arbiter.md
Name: sat_adder_rr_arbiter

Overview:
Shares one saturating adder datapath between NUM_REQ requesters using round-robin arbitration. Each request carries two operands and a signed/unsigned select. The block returns one saturated sum per accepted request through a single registered output stage with valid/ready backpressure. It also keeps a per-requester sticky overflow flag. It sits between execute-side units that need clamped addition, such as address/offset clamps and saturating counters, and the shared adder datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)
NUM_REQ, 4, number of requesters (2..8); IDW = $clog2(NUM_REQ) is a derived localparam

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant/accept (combinational)
req_a  input  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand B, same packing
req_signed  input  NUM_REQ  1 = two's-complement saturating add, 0 = unsigned saturating add
rsp_valid  output  1  response register holds a valid result
rsp_ready  input  1  consumer accepts the response
rsp_id  output  IDW  index of the requester that owns the response
rsp_result  output  WIDTH  saturated sum
rsp_po  output  1  positive overflow occurred (result clamped high)
rsp_no  output  1  negative overflow occurred (result clamped low)
ovf_clr  input  NUM_REQ  per-requester sticky-flag clear
ovf_sticky  output  NUM_REQ  sticky overflow flag per requester

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - rsp_valid=0; rsp_id, rsp_result, rsp_po and rsp_no = 0.
  - ovf_sticky = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
- Accept condition: can_accept = !rsp_valid || rsp_ready.
- Arbitration:
  - Search order starts at the pointer and proceeds ptr, ptr+1, … modulo NUM_REQ.
  - The first index with req_valid set wins.
  - req_ready[win] = can_accept; all other req_ready bits = 0.
  - req_ready is never asserted for a requester whose req_valid is low.
- On accept (req_valid[win] && req_ready[win]), the response register loads the win's id, result, po and no on the next edge. Latency is one cycle, and at most one accept happens per cycle.
- Pointer update: the pointer becomes win+1 (wrapping at NUM_REQ) only on accept. A cycle with no accept leaves the pointer unchanged.
- Response register behaviour:
  - If rsp_valid && !rsp_ready, all rsp_* outputs hold stable and no grant is issued.
  - If rsp_valid && rsp_ready with no new accept, rsp_valid goes to 0.
  - Drain and refill in the same cycle is allowed, giving full throughput of one result per cycle.
- Signed arithmetic (req_signed=1), with s = A+B modulo 2^WIDTH:
  - po = !A[msb] & !B[msb] & s[msb]; result = 0111…1.
  - no = A[msb] & B[msb] & !s[msb]; result = 1000…0.
  - Otherwise result = s.
- Unsigned arithmetic (req_signed=0), using a WIDTH+1-bit sum:
  - po = carry out; result = all ones when po.
  - no = 0 always.
- po and no are mutually exclusive.
- Sticky flags:
  - On accept from requester i with po|no, ovf_sticky[i] sets on the next edge.
  - ovf_clr[i] clears ovf_sticky[i].
  - If set and clear hit the same cycle, set wins.
- An operand change while req_valid is high and no grant has been given is legal. The sampled value is the one present in the accept cycle.
- Reset asserted mid-operation drops any pending response. There is no partial state.

Test Plan:
- Reset check (WIDTH=8, NUM_REQ=4): assert rst_n=0 mid-cycle -> rsp_valid=0, ovf_sticky=0000 immediately, without waiting for a clock edge.
- Signed saturation:
  - req0: 0x70+0x20 signed -> next cycle rsp_result=0x7F, rsp_po=1, rsp_id=0, ovf_sticky[0]=1.
  - req1: 0x80+0xF0 -> 0x80, rsp_no=1.
  - req2: 0x05+0xFE -> 0x03, no flags.
- Unsigned saturation:
  - req3: 0xF0+0x20 unsigned -> 0xFF, rsp_po=1.
  - 0x10+0x20 -> 0x30, flags 0.
  - 0x80+0x80 -> 0xFF, rsp_no=0.
- Round-robin fairness: all four req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 with one result per cycle, rsp_valid continuously 1.
- Backpressure: rsp_ready=0 while rsp_valid=1 -> req_ready=0000 and rsp_* stable for 3 cycles. Raise rsp_ready -> same cycle grant to the next requester in order, new result next cycle.
- Sticky collision and mid-op reset:
  - ovf_clr[0]=1 in the same cycle as a req0 overflow accept -> ovf_sticky[0]=1.
  - ovf_clr[0] alone -> 0.
  - Reset asserted while rsp_valid=1 -> rsp_valid=0. After release, requester 0 wins first.
